// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage execution unit for the MIPS pipeline.
// It contains a registered single-cycle ALU and an iterative multiply/divide
// sequencer that owns the architectural HI/LO registers.
// The multiply uses shift-add and the divide uses restoring subtraction.
// Both work on operand magnitudes and apply the sign correction in one
// final DONE cycle.
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int IMM_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [4:0]       ALUCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             res_valid,
  output logic             ovf,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_AND   = 5'd1;
  localparam logic [4:0] OP_XOR   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_NOR   = 5'd4;
  localparam logic [4:0] OP_SUB   = 5'd5;
  localparam logic [4:0] OP_ANDI  = 5'd6;
  localparam logic [4:0] OP_XORI  = 5'd7;
  localparam logic [4:0] OP_ORI   = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd16;
  localparam logic [4:0] OP_SRL   = 5'd17;
  localparam logic [4:0] OP_SRA   = 5'd18;
  localparam logic [4:0] OP_SLT   = 5'd19;
  localparam logic [4:0] OP_SLTU  = 5'd20;
  localparam logic [4:0] OP_MULT  = 5'd24;
  localparam logic [4:0] OP_MULTU = 5'd25;
  localparam logic [4:0] OP_DIV   = 5'd26;
  localparam logic [4:0] OP_DIVU  = 5'd27;
  localparam logic [4:0] OP_MFHI  = 5'd28;
  localparam logic [4:0] OP_MFLO  = 5'd29;
  localparam logic [4:0] OP_MTHI  = 5'd30;
  localparam logic [4:0] OP_MTLO  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement magnitude, only when the operand is signed and negative.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Conditional two's-complement negation used by the sign fixup.
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic en);
    if (en) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   hi_acc;   // product high half / partial remainder
  logic [WIDTH-1:0]   lo_acc;   // product low half / dividend-quotient shifter
  logic [WIDTH-1:0]   opd;      // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   a_orig;   // raw dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_q;    // negate product or quotient
  logic               neg_r;    // negate remainder (dividend was negative)
  logic               div0;

  logic             accept;
  logic             md_start;
  logic             md_signed;
  logic             md_div;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             is_single;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] imm;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_borrow;
  logic             unused_trial_msb;
  logic [2*WIDTH-1:0] prod;

  assign in_ready  = ~busy;
  assign accept    = in_valid & in_ready & ~flush;
  assign md_start  = accept & ((ALUCode == OP_MULT) | (ALUCode == OP_MULTU) |
                               (ALUCode == OP_DIV)  | (ALUCode == OP_DIVU));
  assign md_signed = (ALUCode == OP_MULT) | (ALUCode == OP_DIV);
  assign md_div    = (ALUCode == OP_DIV) | (ALUCode == OP_DIVU);

  assign sum = A + B;
  assign dif = A - B;
  assign imm = {{(WIDTH-IMM_W){1'b0}}, B[IMM_W-1:0]};

  // Single-cycle ALU result and add/sub signed-overflow detection.
  always_comb begin
    alu_res   = {WIDTH{1'b0}};
    alu_ovf   = 1'b0;
    is_single = 1'b1;
    case (ALUCode)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_XOR:  alu_res = A ^ B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ANDI: alu_res = A & imm;
      OP_XORI: alu_res = A ^ imm;
      OP_ORI:  alu_res = A | imm;
      OP_SLL:  alu_res = B << A[SHAMT_W-1:0];
      OP_SRL:  alu_res = B >> A[SHAMT_W-1:0];
      OP_SRA:  alu_res = WIDTH'($signed(B) >>> A[SHAMT_W-1:0]);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MFHI: alu_res = HI;
      OP_MFLO: alu_res = LO;
      default: is_single = 1'b0;
    endcase
  end

  // One multiply or divide iteration on the magnitude registers.
  always_comb begin
    mul_sum    = {1'b0, hi_acc};
    div_shift  = {hi_acc, lo_acc[WIDTH-1]};
    div_trial  = div_shift - {1'b0, opd};
    div_borrow = (div_shift < {1'b0, opd});
    prod       = {hi_acc, lo_acc};
    if (lo_acc[0]) begin
      mul_sum = {1'b0, hi_acc} + {1'b0, opd};
    end else begin
      mul_sum = {1'b0, hi_acc};
    end
  end

  assign unused_trial_msb = div_trial[WIDTH];

  // Registered ALU outputs; res_valid only on a single-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result    <= {WIDTH{1'b0}};
      res_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept && is_single) begin
      Result    <= alu_res;
      res_valid <= 1'b1;
      ovf       <= alu_ovf;
    end else begin
      res_valid <= 1'b0;
      ovf       <= 1'b0;
    end
  end

  // Mul/div sequencer IDLE->RUN->DONE, owning HI/LO and mthi/mtlo writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= {SHAMT_W{1'b0}};
      busy    <= 1'b0;
      md_done <= 1'b0;
      HI      <= {WIDTH{1'b0}};
      LO      <= {WIDTH{1'b0}};
      hi_acc  <= {WIDTH{1'b0}};
      lo_acc  <= {WIDTH{1'b0}};
      opd     <= {WIDTH{1'b0}};
      a_orig  <= {WIDTH{1'b0}};
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            hi_acc <= {WIDTH{1'b0}};
            lo_acc <= mag(A, md_signed);
            opd    <= mag(B, md_signed);
            a_orig <= A;
            is_div <= md_div;
            neg_q  <= md_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= md_signed & A[WIDTH-1];
            div0   <= md_div & (B == {WIDTH{1'b0}});
            cnt    <= SHAMT_W'(WIDTH-1);
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else if (accept && (ALUCode == OP_MTHI)) begin
            HI <= A;
          end else if (accept && (ALUCode == OP_MTLO)) begin
            LO <= A;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (is_div) begin
              hi_acc <= div_borrow ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
              lo_acc <= {lo_acc[WIDTH-2:0], ~div_borrow};
            end else begin
              hi_acc <= mul_sum[WIDTH:1];
              lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
            end
            if (cnt == {SHAMT_W{1'b0}}) begin
              state <= ST_DONE;
            end else begin
              cnt <= cnt - SHAMT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (!is_div) begin
              {HI, LO} <= neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
            end else if (div0) begin
              HI <= a_orig;
              LO <= {WIDTH{1'b1}};
            end else begin
              HI <= cneg(hi_acc, neg_r);
              LO <= cneg(lo_acc, neg_q);
            end
            md_done <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=16.
module tb_alu_muldiv;

  logic clk;
  logic rst_n;
  logic flush;

  logic        v32, rdy32, rv32, ovf32, busy32, done32;
  logic [4:0]  code32;
  logic [31:0] a32, b32, res32, hi32, lo32;

  logic        v16, rdy16, rv16, ovf16, busy16, done16;
  logic [4:0]  code16;
  logic [15:0] a16, b16, res16, hi16, lo16;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(32), .SHAMT_W(5), .IMM_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .flush(flush),
    .ALUCode(code32), .A(a32), .B(b32), .Result(res32), .res_valid(rv32),
    .ovf(ovf32), .busy(busy32), .md_done(done32), .HI(hi32), .LO(lo32)
  );

  alu_muldiv #(.WIDTH(16), .SHAMT_W(4), .IMM_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .flush(1'b0),
    .ALUCode(code16), .A(a16), .B(b16), .Result(res16), .res_valid(rv16),
    .ovf(ovf16), .busy(busy16), .md_done(done16), .HI(hi16), .LO(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one single-cycle op on the 32-bit unit and check the registered result.
  task automatic alu32(input string tag, input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ovf);
    code32 = code; a32 = a; b32 = b; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    chk({tag, "_res"}, 64'(res32), 64'(exp_res));
    chk({tag, "_rv"},  64'(rv32),  64'd1);
    chk({tag, "_ovf"}, 64'(ovf32), 64'(exp_ovf));
  endtask

  // Run one mul/div op on the selected unit; check stall length, md_done and HI/LO.
  task automatic md(input string tag, input bit w16, input logic [4:0] code,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    int lat;
    if (w16) begin
      code16 = code; a16 = a[15:0]; b16 = b[15:0]; v16 = 1'b1;
      lat = 17;
    end else begin
      code32 = code; a32 = a; b32 = b; v32 = 1'b1;
      lat = 33;
    end
    tick();
    v16 = 1'b0;
    v32 = 1'b0;
    chk({tag, "_rv"}, 64'(w16 ? rv16 : rv32), 64'd0);
    cnt = 0;
    while (!(w16 ? rdy16 : rdy32) && cnt < 100) begin
      cnt++;
      tick();
    end
    chk({tag, "_stall"}, 64'(cnt), 64'(lat));
    chk({tag, "_done"}, 64'(w16 ? done16 : done32), 64'd1);
    chk({tag, "_hi"}, w16 ? 64'(hi16) : 64'(hi32), w16 ? 64'(exp_hi[15:0]) : 64'(exp_hi));
    chk({tag, "_lo"}, w16 ? 64'(lo16) : 64'(lo32), w16 ? 64'(exp_lo[15:0]) : 64'(exp_lo));
    tick();
    chk({tag, "_done_pulse"}, 64'(w16 ? done16 : done32), 64'd0);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; flush = 1'b0;
    v32 = 1'b0; code32 = 5'd0; a32 = 32'd0; b32 = 32'd0;
    v16 = 1'b0; code16 = 5'd0; a16 = 16'd0; b16 = 16'd0;
    #22;
    chk("rst_result", 64'(res32), 64'd0);
    chk("rst_rv", 64'(rv32), 64'd0);
    chk("rst_ovf", 64'(ovf32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_done", 64'(done32), 64'd0);
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    rst_n = 1'b1;
    tick();

    alu32("add_ovf", 5'd0, 32'h40000000, 32'h40000000, 32'h80000000, 1'b1);
    tick();
    chk("idle_rv", 64'(rv32), 64'd0);
    chk("idle_hold", 64'(res32), 64'h80000000);
    alu32("sub_ovf", 5'd5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);

    // back-to-back single-cycle ops, in_valid held high between them
    alu32("and",  5'd1,  32'hFF0C0E10, 32'h0F0F0F0F, 32'h0F0C0E00, 1'b0);
    alu32("sll",  5'd16, 32'h00000004, 32'hFFFFE0FF, 32'hFFFE0FF0, 1'b0);
    alu32("sra",  5'd18, 32'h00000004, 32'hFFFFE0FF, 32'hFFFFFE0F, 1'b0);
    alu32("sltu", 5'd20, 32'hFF000004, 32'h700000FF, 32'h00000000, 1'b0);
    alu32("srl",  5'd17, 32'h00000004, 32'hFFFFE0FF, 32'h0FFFFE0F, 1'b0);
    alu32("slt",  5'd19, 32'hFF000004, 32'h700000FF, 32'h00000001, 1'b0);
    alu32("andi", 5'd6,  32'hFFFFFFFF, 32'hFFFF1234, 32'h00001234, 1'b0);
    alu32("nor",  5'd4,  32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    alu32("xori", 5'd7,  32'h12345678, 32'hFFFF00FF, 32'h12345687, 1'b0);
    alu32("ori",  5'd8,  32'h00000000, 32'hABCD1234, 32'h00001234, 1'b0);
    alu32("add_nov", 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);

    // flushed input is dropped
    code32 = 5'd0; a32 = 32'd1; b32 = 32'd1; v32 = 1'b1; flush = 1'b1;
    tick();
    v32 = 1'b0; flush = 1'b0;
    chk("flush_sq_rv", 64'(rv32), 64'd0);
    chk("flush_sq_hold", 64'(res32), 64'd0);

    // unlisted code: accepted, no effect
    code32 = 5'd10; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    chk("unlisted_rv", 64'(rv32), 64'd0);
    chk("unlisted_ready", 64'(rdy32), 64'd1);

    // mthi / mtlo / mfhi
    code32 = 5'd30; a32 = 32'h00001234; v32 = 1'b1;
    tick();
    chk("mthi_hi", 64'(hi32), 64'h1234);
    chk("mthi_rv", 64'(rv32), 64'd0);
    code32 = 5'd31; a32 = 32'h00005678;
    tick();
    v32 = 1'b0;
    chk("mtlo_lo", 64'(lo32), 64'h5678);
    alu32("mfhi", 5'd28, 32'd0, 32'd0, 32'h00001234, 1'b0);

    md("mult", 1'b0, 5'd24, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    alu32("mflo", 5'd29, 32'd0, 32'd0, 32'hFFFFFFFA, 1'b0);
    md("divu0", 1'b0, 5'd27, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    md("divmin", 1'b0, 5'd26, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    md("divneg", 1'b0, 5'd26, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md("div0s", 1'b0, 5'd26, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    md("multu", 1'b0, 5'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    md("divu", 1'b0, 5'd27, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);

    // div flushed in the 10th RUN cycle leaves HI/LO alone
    code32 = 5'd30; a32 = 32'h00001234; v32 = 1'b1;
    tick();
    code32 = 5'd26; a32 = 32'h00000064; b32 = 32'h00000007;
    tick();
    v32 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_pre_busy", 64'(busy32), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 64'(rdy32), 64'd1);
    chk("flush_busy", 64'(busy32), 64'd0);
    chk("flush_hi", 64'(hi32), 64'h1234);
    chk("flush_lo", 64'(lo32), 64'h0E);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32) dn++;
      tick();
    end
    chk("flush_no_done", 64'(dn), 64'd0);
    chk("flush_hi_late", 64'(hi32), 64'h1234);

    // reset in the middle of a multu
    code32 = 5'd25; a32 = 32'd5; b32 = 32'd7; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy_pre", 64'(busy32), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy32), 64'd0);
    chk("mid_rst_ready", 64'(rdy32), 64'd1);
    chk("mid_rst_hi", 64'(hi32), 64'd0);
    chk("mid_rst_lo", 64'(lo32), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // WIDTH=16 repeats of the mul/div cases
    md("m16_mult", 1'b1, 5'd24, 32'h0000FFFE, 32'h00000003, 32'h0000FFFF, 32'h0000FFFA);
    md("m16_divu0", 1'b1, 5'd27, 32'h00000007, 32'h00000000, 32'h00000007, 32'h0000FFFF);
    md("m16_divmin", 1'b1, 5'd26, 32'h00008000, 32'h0000FFFF, 32'h00000000, 32'h00008000);
    md("m16_divneg", 1'b1, 5'd26, 32'h0000FFF9, 32'h00000002, 32'h0000FFFF, 32'h0000FFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
